// File: rtl/pipe2_ctrl_pkg.sv
// Shared definitions for the stage-2 control-word responder: word layout, FSM states, code widths.
package pipe2_ctrl_pkg;

  localparam int unsigned CodeW   = 4;
  localparam int unsigned OneHotW = 16;
  localparam int unsigned WordW   = 16;

  // Field bit positions within CtrlWord
  localparam int unsigned AssertLsb = 0;
  localparam int unsigned LoadLsb   = 4;
  localparam int unsigned IncLsb    = 8;
  localparam int unsigned IncW      = 2;
  localparam int unsigned AddrLsb   = 10;
  localparam int unsigned AddrW     = 3;
  localparam int unsigned BusReqBit = 13;
  localparam int unsigned PcraBit   = 14;
  localparam int unsigned BreakBit  = 15;

  localparam logic [CodeW-1:0] CodeNone = '0;

  typedef struct packed {
    logic             brk;
    logic             pcraFlip;
    logic             busReq;
    logic [AddrW-1:0] addr;
    logic [IncW-1:0]  inc;
    logic [CodeW-1:0] loadCode;
    logic [CodeW-1:0] assertCode;
  } ctrl_word_t;

  typedef enum logic [2:0] {
    StRstHold,
    StRun,
    StMemWait,
    StExtForce,
    StHalt
  } state_e;

endpackage

// File: rtl/pipe2_sel_decode.sv
// 4-bit selector code to 16-bit one-hot enable; code 0 (none) or Enable low gives all zeros.
module pipe2_sel_decode
  import pipe2_ctrl_pkg::*;
(
  input  logic [CodeW-1:0]   Code,
  input  logic               Enable,
  output logic [OneHotW-1:0] OneHot
);

  always_comb begin
    OneHot = '0;
    if (Enable && (Code != CodeNone)) begin
      OneHot[Code] = 1'b1;
    end
  end

endmodule

// File: rtl/pipe2_ctrl_responder.sv
// Executes stage-2 control words: bus enable decode, memory handshake, external bus arbitration,
// pipeline stall generation and the PCRA_Flip / Reset flag registers.
module pipe2_ctrl_responder
  import pipe2_ctrl_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned MAX_WAIT          = 15,
  parameter int unsigned EXT_STARVE_LIMIT  = 8
) (
  input  logic               ClockIn,
  input  logic               ResetIn,
  input  logic [WordW-1:0]   CtrlWord,
  output logic [OneHotW-1:0] AssertOneHot,
  output logic [OneHotW-1:0] LoadOneHot,
  output logic [IncW-1:0]    IncSel,
  output logic [AddrW-1:0]   AddrSel,
  output logic               MemReq,
  input  logic               MemAck,
  input  logic               ExtBusReq,
  output logic               ExtBusGrant,
  output logic               Stall,
  input  logic               ResumeIn,
  output logic               Halted,
  output logic               PcraFlag,
  output logic               ResetFlag,
  output logic               BusError
);

  localparam int unsigned HoldW   = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned WaitW   = $clog2(MAX_WAIT + 1);
  localparam int unsigned StarveW = $clog2(EXT_STARVE_LIMIT + 1);

  state_e             stateQ, stateD;
  logic [HoldW-1:0]   holdCntQ, holdCntD;
  logic [WaitW-1:0]   waitCntQ, waitCntD;
  logic [StarveW-1:0] starveCntQ, starveCntD;
  ctrl_word_t         wordHeldQ, execWord;
  logic               pcraQ, pcraD;
  logic               busErrQ, busErrD;
  logic               forceExt, execActive, complete, captureWord;

  // A starved external master preempts the word in RUN; the word is held and retried afterwards.
  assign forceExt = (stateQ == StRun) && (starveCntQ == StarveW'(EXT_STARVE_LIMIT));
  assign execWord = (stateQ == StRun) ? ctrl_word_t'(CtrlWord) : wordHeldQ;

  always_comb begin
    stateD      = stateQ;
    holdCntD    = holdCntQ;
    waitCntD    = waitCntQ;
    starveCntD  = starveCntQ;
    pcraD       = pcraQ;
    busErrD     = busErrQ;
    execActive  = 1'b0;
    complete    = 1'b0;
    MemReq      = 1'b0;
    ExtBusGrant = 1'b0;

    unique case (stateQ)
      StRstHold: begin
        if (holdCntQ <= HoldW'(1)) begin
          holdCntD = '0;
          stateD   = StRun;
        end else begin
          holdCntD = holdCntQ - HoldW'(1);
        end
      end
      StRun: begin
        if (forceExt) begin
          stateD = StExtForce;
        end else begin
          execActive  = 1'b1;
          MemReq      = execWord.busReq;
          ExtBusGrant = ExtBusReq & ~execWord.busReq;
          if (ExtBusReq && execWord.busReq) begin
            if (starveCntQ != StarveW'(EXT_STARVE_LIMIT)) starveCntD = starveCntQ + StarveW'(1);
          end else begin
            starveCntD = '0;
          end
          if (execWord.busReq && !MemAck) begin
            stateD   = StMemWait;
            waitCntD = '0;
          end else begin
            complete = 1'b1;
            if (execWord.brk) stateD = StHalt;
          end
        end
      end
      StMemWait: begin
        execActive = 1'b1;
        MemReq     = 1'b1;
        waitCntD   = waitCntQ + WaitW'(1);
        if (MemAck) begin
          complete = 1'b1;
          waitCntD = '0;
          stateD   = execWord.brk ? StHalt : StRun;
        end else if (waitCntQ == WaitW'(MAX_WAIT - 1)) begin
          busErrD  = 1'b1;
          waitCntD = '0;
          stateD   = StHalt;
        end
      end
      StExtForce: begin
        ExtBusGrant = 1'b1;
        starveCntD  = '0;
        if (!ExtBusReq) stateD = StRun;
      end
      StHalt: begin
        if (ResumeIn && !busErrQ) stateD = StRun;
      end
      default: stateD = StRstHold;
    endcase

    if (complete && execWord.pcraFlip) pcraD = ~pcraQ;
  end

  assign captureWord = (stateQ == StRun) && (stateD != StRun);

  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      stateQ     <= StRstHold;
      holdCntQ   <= HoldW'(RESET_HOLD_CYCLES);
      waitCntQ   <= '0;
      starveCntQ <= '0;
      wordHeldQ  <= '0;
      pcraQ      <= 1'b0;
      busErrQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      holdCntQ   <= holdCntD;
      waitCntQ   <= waitCntD;
      starveCntQ <= starveCntD;
      pcraQ      <= pcraD;
      busErrQ    <= busErrD;
      if (captureWord) wordHeldQ <= ctrl_word_t'(CtrlWord);
    end
  end

  assign Stall     = (stateQ != StRun) || forceExt;
  assign Halted    = (stateQ == StHalt);
  assign ResetFlag = (stateQ == StRstHold);
  assign PcraFlag  = pcraQ;
  assign BusError  = busErrQ;
  assign IncSel    = execActive ? execWord.inc : '0;
  assign AddrSel   = execActive ? execWord.addr : '0;

  pipe2_sel_decode u_assert_decode (
    .Code   (execWord.assertCode),
    .Enable (execActive),
    .OneHot (AssertOneHot)
  );

  pipe2_sel_decode u_load_decode (
    .Code   (execWord.loadCode),
    .Enable (complete),
    .OneHot (LoadOneHot)
  );

endmodule

// File: tb/tb_pipe2_ctrl_responder.sv
// Scoreboard bench for pipe2_ctrl_responder: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe2_ctrl_responder;

  localparam int HOLD   = 4;
  localparam int MAXW   = 15;
  localparam int STARVE = 8;

  logic        ClockIn = 1'b0;
  logic        ResetIn = 1'b1;
  logic [15:0] CtrlWord = '0;
  logic        MemAck = 1'b0, ExtBusReq = 1'b0, ResumeIn = 1'b0;
  logic [15:0] AssertOneHot, LoadOneHot;
  logic [1:0]  IncSel;
  logic [2:0]  AddrSel;
  logic        MemReq, ExtBusGrant, Stall, Halted, PcraFlag, ResetFlag, BusError;

  always #5 ClockIn = ~ClockIn;

  pipe2_ctrl_responder #(
    .RESET_HOLD_CYCLES (HOLD),
    .MAX_WAIT          (MAXW),
    .EXT_STARVE_LIMIT  (STARVE)
  ) dut (
    .ClockIn      (ClockIn),
    .ResetIn      (ResetIn),
    .CtrlWord     (CtrlWord),
    .AssertOneHot (AssertOneHot),
    .LoadOneHot   (LoadOneHot),
    .IncSel       (IncSel),
    .AddrSel      (AddrSel),
    .MemReq       (MemReq),
    .MemAck       (MemAck),
    .ExtBusReq    (ExtBusReq),
    .ExtBusGrant  (ExtBusGrant),
    .Stall        (Stall),
    .ResumeIn     (ResumeIn),
    .Halted       (Halted),
    .PcraFlag     (PcraFlag),
    .ResetFlag    (ResetFlag),
    .BusError     (BusError)
  );

  typedef struct {
    int          cyc;
    logic [15:0] asrt;
    logic [15:0] load;
    logic [1:0]  inc;
    logic [2:0]  addr;
    logic        memReq, grant, stall, halted, pcra, rflag, berr;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model state: what the responder is currently doing, in plain terms
  bit          known = 0;
  int          holdLeft;
  bit          waiting, halted, forced, pcra, berr;
  int          waitCycles, starve;
  logic [15:0] heldWord;

  function automatic logic [15:0] onehot(input int code);
    return (code == 0) ? 16'h0000 : 16'(1 << code);
  endfunction

  function automatic logic [15:0] mkw(input int brk, input int pf, input int br, input int addr,
                                      input int inc, input int ld, input int as);
    logic [15:0] w;
    w = 16'((brk << 15) | (pf << 14) | (br << 13) | (addr << 10) | (inc << 8) | (ld << 4) | as);
    return w;
  endfunction

  task automatic show_word(input logic [15:0] w, inout exp_t e);
    e.asrt = onehot(int'(w[3:0]));
    e.inc  = w[9:8];
    e.addr = w[12:10];
  endtask

  task automatic model_step();
    exp_t        e;
    logic [15:0] w;
    e = '{cyc: cycle, asrt: 16'h0, load: 16'h0, inc: 2'b0, addr: 3'b0, memReq: 0, grant: 0,
          stall: 0, halted: 0, pcra: pcra, rflag: 0, berr: berr};
    if (holdLeft > 0) begin
      e.rflag = 1; e.stall = 1;
      holdLeft--;
    end else if (halted) begin
      e.stall = 1; e.halted = 1;
      if (ResumeIn && !berr) halted = 0;
    end else if (forced) begin
      e.stall = 1; e.grant = 1;
      starve = 0;
      if (!ExtBusReq) forced = 0;
    end else if (waiting) begin
      w = heldWord;
      show_word(w, e);
      e.stall = 1; e.memReq = 1;
      waitCycles++;
      if (MemAck) begin
        e.load  = onehot(int'(w[7:4]));
        waiting = 0;
        if (w[14]) pcra = ~pcra;
        if (w[15]) halted = 1;
      end else if (waitCycles == MAXW) begin
        berr = 1; waiting = 0; halted = 1;
      end
    end else if (starve == STARVE) begin
      e.stall = 1;
      forced  = 1;
    end else begin
      w = CtrlWord;
      show_word(w, e);
      e.memReq = w[13];
      e.grant  = ExtBusReq && !w[13];
      if (ExtBusReq && w[13]) starve = (starve < STARVE) ? starve + 1 : STARVE;
      else starve = 0;
      if (w[13] && !MemAck) begin
        waiting = 1; waitCycles = 0; heldWord = w;
      end else begin
        e.load = onehot(int'(w[7:4]));
        if (w[14]) pcra = ~pcra;
        if (w[15]) halted = 1;
      end
    end
    if (known) expQ.push_back(e);
    if (ResetIn) begin
      known = 1; holdLeft = HOLD; waiting = 0; halted = 0; forced = 0;
      pcra = 0; berr = 0; waitCycles = 0; starve = 0; heldWord = '0;
    end
  endtask

  task automatic drive(input logic rst, input logic [15:0] cw, input logic ack, input logic ereq,
                       input logic res);
    @(posedge ClockIn);
    #1;
    cycle++;
    ResetIn = rst; CtrlWord = cw; MemAck = ack; ExtBusReq = ereq; ResumeIn = res;
    model_step();
  endtask

  task automatic chk(input string name, input int cyc, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  exp_t monE;
  always @(negedge ClockIn) begin
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      chk("AssertOneHot", monE.cyc, AssertOneHot, monE.asrt);
      chk("LoadOneHot", monE.cyc, LoadOneHot, monE.load);
      chk("IncSel", monE.cyc, 16'(IncSel), 16'(monE.inc));
      chk("AddrSel", monE.cyc, 16'(AddrSel), 16'(monE.addr));
      chk("MemReq", monE.cyc, 16'(MemReq), 16'(monE.memReq));
      chk("ExtBusGrant", monE.cyc, 16'(ExtBusGrant), 16'(monE.grant));
      chk("Stall", monE.cyc, 16'(Stall), 16'(monE.stall));
      chk("Halted", monE.cyc, 16'(Halted), 16'(monE.halted));
      chk("PcraFlag", monE.cyc, 16'(PcraFlag), 16'(monE.pcra));
      chk("ResetFlag", monE.cyc, 16'(ResetFlag), 16'(monE.rflag));
      chk("BusError", monE.cyc, 16'(BusError), 16'(monE.berr));
    end
  end

  logic [15:0] w1, w2, rw;

  initial begin
    // Reset, then the post-reset hold window
    repeat (2) drive(1, 16'h0, 0, 0, 0);
    repeat (6) drive(0, 16'h0, 0, 0, 0);

    // Zero-wait word: assert 3, load 5
    drive(0, mkw(0, 0, 0, 1, 2, 5, 3), 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0);

    // Memory word acked three cycles after presentation; next word held behind the stall
    w1 = mkw(0, 1, 1, 2, 1, 6, 4);
    w2 = mkw(0, 0, 0, 5, 3, 7, 2);
    drive(0, w1, 0, 0, 0);
    drive(0, w2, 0, 0, 0);
    drive(0, w2, 0, 0, 0);
    drive(0, w2, 1, 0, 0);
    drive(0, w2, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0);

    // Timeout: ack never comes, resume ignored, only reset recovers
    repeat (18) drive(0, mkw(0, 1, 1, 1, 1, 9, 6), 0, 0, 0);
    repeat (4) drive(0, 16'h0, 0, 0, 1);
    drive(1, 16'h0, 0, 0, 0);
    repeat (5) drive(0, 16'h0, 0, 0, 0);

    // External master starved by back-to-back memory words, then forced grant
    repeat (12) drive(0, mkw(0, 0, 1, 3, 0, 4, 8), 1, 1, 0);
    drive(0, mkw(0, 0, 1, 3, 0, 4, 8), 1, 0, 0);
    repeat (2) drive(0, 16'h0, 0, 0, 0);

    // Break with PCRA flip, then resume pulse
    drive(0, mkw(1, 1, 0, 0, 0, 1, 15), 0, 0, 0);
    repeat (3) drive(0, 16'h0, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    repeat (2) drive(0, mkw(0, 0, 0, 4, 1, 2, 1), 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rw     = 16'($urandom);
      rw[15] = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 99) == 0), rw, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end
    drive(0, 16'h0, 0, 0, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge ClockIn);
    @(posedge ClockIn);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
